// File: rtl/logic_unit_checker.sv
// Response checker for the OR/NOR selectable logic unit: scores sampled {a,b,select,dut_out}
// beats against select ? ~(a|b) : (a|b). Optional coverage ports under LOGIC_CHK_COVERAGE_EN.
module logic_unit_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             select,
  input  logic             dut_out,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             error,
  output logic [2:0]       first_fail,
  output logic             busy,
  output logic             done,
`ifdef LOGIC_CHK_COVERAGE_EN
  output logic [7:0]       cov_mask,
  output logic             cov_full,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready are both 1.
  // in_ready is a flop that depends only on the FSM, never on in_valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             error_q, error_d;
  logic [2:0]       first_fail_q, first_fail_d;
  logic             stg_valid_q, stg_valid_d;
  logic [2:0]       stg_vec_q, stg_vec_d;
  logic             stg_out_q, stg_out_d;
`ifdef LOGIC_CHK_COVERAGE_EN
  logic [7:0]       cov_mask_q, cov_mask_d;
`endif

  logic accept;
  logic run_start;
  logic last_accept;
  logic stg_exp;
  logic stg_mismatch;

  always_comb begin
    accept       = in_valid & in_ready_q;
    run_start    = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    last_accept  = accept & (beat_cnt_q == LAST_BEAT);
    stg_exp      = stg_vec_q[0] ? ~(stg_vec_q[2] | stg_vec_q[1])
                                :  (stg_vec_q[2] | stg_vec_q[1]);
    // Case-inequality so an X/Z response is scored as a failure in simulation.
    stg_mismatch = (stg_out_q !== stg_exp);

    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_accept) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN) | (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);

    stg_valid_d = accept;
    stg_vec_d   = accept ? {a, b, select} : stg_vec_q;
    stg_out_d   = accept ? dut_out : stg_out_q;

    beat_cnt_d = beat_cnt_q;
    if (run_start)   beat_cnt_d = '0;
    else if (accept) beat_cnt_d = beat_cnt_q + 1'b1;

    pass_d       = pass_q;
    fail_d       = fail_q;
    error_d      = error_q;
    first_fail_d = first_fail_q;
    if (run_start) begin
      pass_d       = '0;
      fail_d       = '0;
      error_d      = 1'b0;
      first_fail_d = 3'b000;
    end else if (stg_valid_q) begin
      if (stg_mismatch) begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
        if (!error_q) begin
          error_d      = 1'b1;
          first_fail_d = stg_vec_q;
        end
      end else begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end
    end

`ifdef LOGIC_CHK_COVERAGE_EN
    cov_mask_d = cov_mask_q;
    if (run_start)   cov_mask_d = 8'h00;
    else if (accept) cov_mask_d = cov_mask_q | (8'h01 << {a, b, select});
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beat_cnt_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      error_q      <= 1'b0;
      first_fail_q <= 3'b000;
      stg_valid_q  <= 1'b0;
      stg_vec_q    <= 3'b000;
      stg_out_q    <= 1'b0;
`ifdef LOGIC_CHK_COVERAGE_EN
      cov_mask_q   <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      beat_cnt_q   <= beat_cnt_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      error_q      <= error_d;
      first_fail_q <= first_fail_d;
      stg_valid_q  <= stg_valid_d;
      stg_vec_q    <= stg_vec_d;
      stg_out_q    <= stg_out_d;
`ifdef LOGIC_CHK_COVERAGE_EN
      cov_mask_q   <= cov_mask_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign error      = error_q;
  assign first_fail = first_fail_q;
  assign state_dbg  = state_q;
`ifdef LOGIC_CHK_COVERAGE_EN
  assign cov_mask   = cov_mask_q;
  assign cov_full   = &cov_mask_q;
`endif

endmodule
